dmem_lsu: RTL and testbench
===========================

// Module: dmem_lsu
// PURPOSE
//  Load/store unit between the RV32 pipeline MEM stage and dmem; sole driver of dmem addr/w_data/ctrl/w_en.
//  Takes one request at a time (valid/ready), always accesses dmem as aligned words (ctrl=3'b010),
//  does byte/half extraction and sign/zero-extension itself, and performs SB/SH as read-modify-write.
//  Misaligned or illegal-funct3 requests get an error response and never touch dmem.
// PARAMETERS
//  XLEN        32  data/address width; only 32 is supported
//  BADF3_ERR   1   1: illegal funct3 -> rsp_err; 0: treated as LW/SW (alignment still checked as word)
// PORTS
//  CLK         in   1     clock; all state changes on posedge
//  RST         in   1     asynchronous, active-high reset
//  req_valid   in   1     request present
//  req_ready   out  1     unit can accept; req_valid&&req_ready at posedge = accept
//  req_we      in   1     1 = store, 0 = load
//  req_funct3  in   3     RV32 funct3: load 000 LB,001 LH,010 LW,100 LBU,101 LHU; store 000 SB,001 SH,010 SW
//  req_addr    in   32    byte address
//  req_wdata   in   32    store data; low byte/half used for SB/SH
//  rsp_valid   out  1     response present; held until rsp_ready
//  rsp_ready   in   1     consumer takes response at posedge when rsp_valid&&rsp_ready
//  rsp_rdata   out  32    extended load data; 0 for stores and errors
//  rsp_err     out  1     misaligned or illegal funct3
//  mem_addr    out  32    to dmem.addr; always {addr[31:2],2'b00}
//  mem_wdata   out  32    to dmem.w_data
//  mem_ctrl    out  3     to dmem.ctrl; constant 3'b010
//  mem_wen     out  1     to dmem.w_en; dmem writes at posedge while high
//  mem_rdata   in   32    from dmem.outdata; combinational word read of mem_addr
// BEHAVIOUR
//  Reset (async, immediate): state IDLE; req_ready=1 once released; rsp_valid=0, rsp_err=0, rsp_rdata=0,
//   mem_wen=0, mem_addr=0, mem_wdata=0. Request latches cleared. Reset mid-operation aborts with no write.
//  States: IDLE, LOAD, MERGE, WRITE, RESP. req_ready=1 only in IDLE. mem_wen=1 only in WRITE (decoded from state).
//  IDLE, accept: latch we/funct3/addr/wdata; mem_addr<= word address. Next state:
//   err (LH/LHU/SH with addr[0]!=0; LW/SW with addr[1:0]!=0; illegal f3 when BADF3_ERR) -> RESP, rsp_err=1, rsp_rdata=0.
//   load -> LOAD; SW -> WRITE (mem_wdata<=req_wdata); SB/SH -> MERGE.
//  LOAD (1 cyc): capture mem_rdata, select byte addr[1:0] / half addr[1], sign-extend (LB/LH) or zero-extend
//   (LBU/LHU) into rsp_rdata -> RESP.
//  MERGE (1 cyc): mem_wdata<=mem_rdata with byte lane addr[1:0] (SB) or half lane addr[1] (SH) replaced
//   by req_wdata[7:0]/[15:0] -> WRITE.
//  WRITE (1 cyc): mem_wen=1; dmem commits at end of cycle -> RESP, rsp_err=0, rsp_rdata=0.
//  RESP: rsp_valid=1; stays until rsp_ready; on handshake -> IDLE, rsp_valid=0. No new accept while in RESP.
//  Latency accept-edge to rsp_valid: load 2, SW 2, SB/SH 3, error 1 cycle.
//  Byte lanes little-endian: lane n = bits [8n+7:8n]. req_* ignored outside IDLE; req_valid may drop freely.
//  Outputs stable between state changes; rsp_rdata/rsp_err hold through RESP stall.
// TESTING
//  SW addr=0x0 data=0x12345678, then LW 0x0 -> rsp_rdata=0x12345678, err=0; mem_wen high exactly 1 cycle.
//  After above: LB 0x1 -> 0x00000056; LH 0x2 -> 0x00001234; LBU 0x3 -> 0x00000012; LHU 0x0 -> 0x00005678.
//  SW 0x4=0xF123F6F8; LB 0x4 -> 0xFFFFFFF8; LH 0x6 -> 0xFFFFF123; LBU 0x5 -> 0x000000F6; LHU 0x4 -> 0x0000F6F8.
//  SB 0x1 data=0xAB over 0x12345678 -> LW 0x0 = 0x1234AB78; SH 0x2 data=0xBEEF -> 0xBEEFAB78; 3-cycle latency.
//  LW 0x2 and SH 0x1 -> rsp_err=1, rsp_rdata=0, one cycle latency, mem_wen never high, memory unchanged.
//  rsp_ready held low 5 cycles: rsp_valid/rdata stable, req_ready=0; RST pulsed during WRITE -> mem_wen=0, word unchanged.

Source files
------------

// File: rtl/dmem_lsu.sv
// dmem_lsu: load/store unit between the MEM stage and a word-wide data memory.
// Accesses dmem only as aligned words; byte/half loads are extracted and
// extended here, and SB/SH are performed as read-modify-write.
module dmem_lsu #(
    parameter int unsigned XLEN      = 32,
    parameter bit          BADF3_ERR = 1'b1
) (
    input  logic            CLK,
    input  logic            RST,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic            req_we,
    input  logic [2:0]      req_funct3,
    input  logic [XLEN-1:0] req_addr,
    input  logic [XLEN-1:0] req_wdata,
    output logic            rsp_valid,
    input  logic            rsp_ready,
    output logic [XLEN-1:0] rsp_rdata,
    output logic            rsp_err,
    output logic [XLEN-1:0] mem_addr,
    output logic [XLEN-1:0] mem_wdata,
    output logic [2:0]      mem_ctrl,
    output logic            mem_wen,
    input  logic [XLEN-1:0] mem_rdata
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_LOAD  = 3'd1;
    localparam logic [2:0] S_MERGE = 3'd2;
    localparam logic [2:0] S_WRITE = 3'd3;
    localparam logic [2:0] S_RESP  = 3'd4;

    logic [2:0]  state;
    logic        r_we;
    logic [2:0]  r_f3;
    logic [1:0]  r_off;
    logic [15:0] r_wdata;

    logic        f3_legal;
    logic [2:0]  eff_f3;
    logic        misaligned;
    logic        req_err;
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;
    logic [XLEN-1:0] ld_data;
    logic [XLEN-1:0] merged;

    assign req_ready = (state == S_IDLE);
    assign rsp_valid = (state == S_RESP);
    assign mem_wen   = (state == S_WRITE);
    assign mem_ctrl  = 3'b010;

    // Decode the incoming request: legality, effective width and alignment.
    always_comb begin
        f3_legal = 1'b0;
        if (req_we) begin
            f3_legal = (req_funct3 == 3'b000) || (req_funct3 == 3'b001) ||
                       (req_funct3 == 3'b010);
        end else begin
            f3_legal = (req_funct3 == 3'b000) || (req_funct3 == 3'b001) ||
                       (req_funct3 == 3'b010) || (req_funct3 == 3'b100) ||
                       (req_funct3 == 3'b101);
        end
        // Illegal funct3 degrades to a word access when not flagged as an error.
        eff_f3     = f3_legal ? req_funct3 : 3'b010;
        misaligned = ((eff_f3[1:0] == 2'b01) && req_addr[0]) ||
                     ((eff_f3[1:0] == 2'b10) && (req_addr[1:0] != 2'b00));
        req_err    = misaligned || (!f3_legal && BADF3_ERR);
    end

    // Lane extraction for loads and lane replacement for sub-word stores.
    always_comb begin
        ld_byte = mem_rdata[8*r_off +: 8];
        ld_half = r_off[1] ? mem_rdata[31:16] : mem_rdata[15:0];
        unique case (r_f3)
            3'b000:  ld_data = {{(XLEN-8){ld_byte[7]}}, ld_byte};
            3'b001:  ld_data = {{(XLEN-16){ld_half[15]}}, ld_half};
            3'b100:  ld_data = {{(XLEN-8){1'b0}}, ld_byte};
            3'b101:  ld_data = {{(XLEN-16){1'b0}}, ld_half};
            default: ld_data = mem_rdata;
        endcase
        merged = mem_rdata;
        if (r_f3[0]) begin
            if (r_off[1]) merged[31:16] = r_wdata;
            else          merged[15:0]  = r_wdata;
        end else begin
            merged[8*r_off +: 8] = r_wdata[7:0];
        end
    end

    // Sequencer and all registered outputs.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state     <= S_IDLE;
            r_we      <= 1'b0;
            r_f3      <= 3'b000;
            r_off     <= 2'b00;
            r_wdata   <= '0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (req_valid) begin
                        r_we      <= req_we;
                        r_f3      <= eff_f3;
                        r_off     <= req_addr[1:0];
                        r_wdata   <= req_wdata[15:0];
                        mem_addr  <= {req_addr[XLEN-1:2], 2'b00};
                        rsp_rdata <= '0;
                        rsp_err   <= 1'b0;
                        if (req_err) begin
                            rsp_err <= 1'b1;
                            state   <= S_RESP;
                        end else if (!req_we) begin
                            state <= S_LOAD;
                        end else if (eff_f3 == 3'b010) begin
                            mem_wdata <= req_wdata;
                            state     <= S_WRITE;
                        end else begin
                            state <= S_MERGE;
                        end
                    end
                end
                S_LOAD: begin
                    rsp_rdata <= r_we ? '0 : ld_data;
                    state     <= S_RESP;
                end
                S_MERGE: begin
                    mem_wdata <= merged;
                    state     <= S_WRITE;
                end
                S_WRITE: begin
                    rsp_err   <= 1'b0;
                    rsp_rdata <= '0;
                    state     <= S_RESP;
                end
                S_RESP: begin
                    if (rsp_ready) state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_lsu.sv
// tb_dmem_lsu: directed test of dmem_lsu against a behavioural word memory,
// with a response scoreboard and latency / write-enable checks.
module tb_dmem_lsu;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_we = 1'b0;
    logic [2:0]  req_funct3 = 3'b000;
    logic [31:0] req_addr = 32'h0;
    logic [31:0] req_wdata = 32'h0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [2:0]  mem_ctrl;
    logic        mem_wen;
    logic [31:0] mem_rdata;

    logic [31:0] mem [16];
    logic [32:0] sb_q [$];
    int vectors = 0;
    int miscompares = 0;

    dmem_lsu dut (
        .CLK(CLK), .RST(RST),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
        .rsp_err(rsp_err), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_ctrl(mem_ctrl), .mem_wen(mem_wen), .mem_rdata(mem_rdata)
    );

    always #5 CLK = ~CLK;

    // Behavioural dmem: combinational read, write at posedge while w_en high.
    assign mem_rdata = mem[mem_addr[5:2]];
    always @(posedge CLK) if (mem_wen) mem[mem_addr[5:2]] <= mem_wdata;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Issue one request, push its expected response, and check it on arrival.
    task automatic xact(input string tag, input logic we, input logic [2:0] f3,
                        input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [31:0] exp_rdata, input logic exp_err,
                        input int exp_lat, input int stall);
        int lat;
        int wens;
        logic [32:0] exp;
        logic [31:0] held;
        sb_q.push_back({exp_err, exp_rdata});
        @(negedge CLK);
        check({tag, " req_ready"}, {31'b0, req_ready}, 32'd1);
        req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wdata;
        lat = 0;
        wens = 0;
        do begin
            @(posedge CLK);
            lat++;
            @(negedge CLK);
            req_valid = 1'b0;
            req_addr = 32'hFFFF_FFFF;
            req_wdata = 32'hA5A5_A5A5;
            if (mem_wen) wens++;
            check({tag, " mem_ctrl"}, {29'b0, mem_ctrl}, 32'h2);
            check({tag, " mem_addr"}, mem_addr, {addr[31:2], 2'b00});
        end while (!rsp_valid && lat < 8);
        check({tag, " latency"}, lat, exp_lat);
        check({tag, " wen cycles"}, wens, (we && !exp_err) ? 1 : 0);
        if (rsp_valid && sb_q.size() > 0) begin
            exp = sb_q.pop_front();
            check({tag, " rdata"}, rsp_rdata, exp[31:0]);
            check({tag, " err"}, {31'b0, rsp_err}, {31'b0, exp[32]});
        end
        held = rsp_rdata;
        for (int i = 0; i < stall; i++) begin
            @(negedge CLK);
            check({tag, " stall valid"}, {31'b0, rsp_valid}, 32'd1);
            check({tag, " stall rdata"}, rsp_rdata, held);
            check({tag, " stall ready"}, {31'b0, req_ready}, 32'd0);
        end
        rsp_ready = 1'b1;
        @(posedge CLK);
        @(negedge CLK);
        rsp_ready = 1'b0;
        check({tag, " rsp drop"}, {31'b0, rsp_valid}, 32'd0);
    endtask

    initial begin
        for (int i = 0; i < 16; i++) mem[i] = 32'h0;
        #12;
        check("reset req_ready", {31'b0, req_ready}, 32'd1);
        check("reset rsp_valid", {31'b0, rsp_valid}, 32'd0);
        check("reset mem_wen", {31'b0, mem_wen}, 32'd0);
        check("reset mem_addr", mem_addr, 32'h0);
        check("reset rsp_rdata", rsp_rdata, 32'h0);
        @(negedge CLK);
        RST = 1'b0;

        xact("SW0", 1'b1, 3'b010, 32'h0, 32'h1234_5678, 32'h0, 1'b0, 2, 0);
        check("mem0 after SW", mem[0], 32'h1234_5678);
        xact("LW0", 1'b0, 3'b010, 32'h0, 32'h0, 32'h1234_5678, 1'b0, 2, 0);
        xact("LB1", 1'b0, 3'b000, 32'h1, 32'h0, 32'h0000_0056, 1'b0, 2, 0);
        xact("LH2", 1'b0, 3'b001, 32'h2, 32'h0, 32'h0000_1234, 1'b0, 2, 0);
        xact("LBU3", 1'b0, 3'b100, 32'h3, 32'h0, 32'h0000_0012, 1'b0, 2, 0);
        xact("LHU0", 1'b0, 3'b101, 32'h0, 32'h0, 32'h0000_5678, 1'b0, 2, 0);

        xact("SW4", 1'b1, 3'b010, 32'h4, 32'hF123_F6F8, 32'h0, 1'b0, 2, 0);
        xact("LB4", 1'b0, 3'b000, 32'h4, 32'h0, 32'hFFFF_FFF8, 1'b0, 2, 0);
        xact("LH6", 1'b0, 3'b001, 32'h6, 32'h0, 32'hFFFF_F123, 1'b0, 2, 0);
        xact("LBU5", 1'b0, 3'b100, 32'h5, 32'h0, 32'h0000_00F6, 1'b0, 2, 0);
        xact("LHU4", 1'b0, 3'b101, 32'h4, 32'h0, 32'h0000_F6F8, 1'b0, 2, 0);

        xact("SB1", 1'b1, 3'b000, 32'h1, 32'hFFFF_FFAB, 32'h0, 1'b0, 3, 0);
        xact("LW0 after SB", 1'b0, 3'b010, 32'h0, 32'h0, 32'h1234_AB78, 1'b0, 2, 0);
        xact("SH2", 1'b1, 3'b001, 32'h2, 32'h1234_BEEF, 32'h0, 1'b0, 3, 0);
        xact("LW0 after SH", 1'b0, 3'b010, 32'h0, 32'h0, 32'hBEEF_AB78, 1'b0, 2, 0);
        xact("SB7", 1'b1, 3'b000, 32'h7, 32'h0000_0011, 32'h0, 1'b0, 3, 0);
        check("mem1 after SB7", mem[1], 32'h1123_F6F8);

        xact("LW2 misaligned", 1'b0, 3'b010, 32'h2, 32'h0, 32'h0, 1'b1, 1, 0);
        xact("SH1 misaligned", 1'b1, 3'b001, 32'h1, 32'hFFFF_FFFF, 32'h0, 1'b1, 1, 0);
        xact("LH3 misaligned", 1'b0, 3'b001, 32'h3, 32'h0, 32'h0, 1'b1, 1, 0);
        xact("load f3 011", 1'b0, 3'b011, 32'h0, 32'h0, 32'h0, 1'b1, 1, 0);
        xact("store f3 100", 1'b1, 3'b100, 32'h0, 32'hFFFF_FFFF, 32'h0, 1'b1, 1, 0);
        check("mem0 after errors", mem[0], 32'hBEEF_AB78);

        xact("LB0 stall", 1'b0, 3'b000, 32'h0, 32'h0, 32'h0000_0078, 1'b0, 2, 5);

        xact("SW8", 1'b1, 3'b010, 32'h8, 32'h1111_1111, 32'h0, 1'b0, 2, 0);
        // Abort a store with reset while it sits in WRITE.
        @(negedge CLK);
        req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'b010;
        req_addr = 32'h8; req_wdata = 32'h2222_2222;
        @(posedge CLK);
        @(negedge CLK);
        req_valid = 1'b0;
        check("pre-abort wen", {31'b0, mem_wen}, 32'd1);
        RST = 1'b1;
        #1;
        check("abort wen", {31'b0, mem_wen}, 32'd0);
        @(negedge CLK);
        RST = 1'b0;
        check("abort mem8", mem[2], 32'h1111_1111);
        check("abort req_ready", {31'b0, req_ready}, 32'd1);
        check("abort rsp_valid", {31'b0, rsp_valid}, 32'd0);
        check("abort mem_wdata", mem_wdata, 32'h0);
        xact("LW8 after abort", 1'b0, 3'b010, 32'h8, 32'h0, 32'h1111_1111, 1'b0, 2, 0);

        check("scoreboard empty", sb_q.size(), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
